// File: rtl/im_loader.sv
// rtl/im_loader.sv - framed byte-stream loader for the 16x8 instruction memory.
// Frame: LEN, LEN program bytes, CSUM; core start is released only after a clean load.
module im_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [DATA_W-1:0] im_wdata,
  output logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_t;

  localparam logic [DATA_W-1:0] DEPTH_B = DATA_W'(DEPTH);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W:0]     cnt_inc;
  logic                accept;

  assign in_ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign accept   = in_valid && in_ready;
  assign cnt_inc  = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    // A restart wins over any byte accepted in the same cycle; that byte is dropped.
    if (load_req) begin
      state_d = S_LEN;
      len_d   = '0;
      cnt_d   = '0;
      sum_d   = '0;
    end else begin
      case (state_q)
        S_LEN: begin
          if (accept) begin
            if (in_data == '0 || in_data > DEPTH_B) begin
              state_d = S_ERR;
            end else begin
              len_d   = in_data[ADDR_W:0];
              state_d = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            we_d    = 1'b1;
            waddr_d = cnt_q[ADDR_W-1:0];
            wdata_d = in_data;
            cnt_d   = cnt_inc;
            sum_d   = sum_q + in_data;
            if (cnt_inc == len_q) begin
              state_d = S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (accept) begin
            state_d = (in_data == sum_q) ? S_RUN : S_ERR;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // RUN is entered on the CSUM edge, so start trails the final write by a cycle.
  assign im_we      = we_q;
  assign im_waddr   = waddr_q;
  assign im_wdata   = wdata_q;
  assign start      = (state_q == S_RUN);
  assign done       = (state_q == S_RUN);
  assign err        = (state_q == S_ERR);
  assign busy       = in_ready;
  assign word_count = cnt_q;

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Writer side of the instruction-memory interface. The core only ever reads the 16 x 8-bit instruction memory; this block fills it.
- Accepts a framed program byte stream over a valid/ready handshake and writes each byte into the memory's write port at consecutive addresses.
- Verifies an 8-bit checksum at the end of the frame.
- Drives the core's `start` only after a clean load.

Parameters:
- ADDR_W, 4, instruction memory address width
- DATA_W, 8, instruction width
- DEPTH, 16, maximum program length in words (2**ADDR_W)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- load_req  in  1  single-cycle request to begin or restart a load
- in_valid  in  1  in_data holds a byte
- in_ready  out  1  loader accepts a byte this cycle
- in_data  in  DATA_W  frame byte
- im_we  out  1  instruction memory write enable
- im_waddr  out  ADDR_W  write address
- im_wdata  out  DATA_W  write data
- start  out  1  core run enable, drives the core's start input
- busy  out  1  frame in progress
- done  out  1  last load succeeded
- err  out  1  last load failed
- word_count  out  ADDR_W+1  program bytes written in the current/last load

Behaviour:
- Reset (async, any state, mid-frame included):
  - state=IDLE.
  - All outputs 0: in_ready, im_we, im_waddr, im_wdata, start, busy, done, err, word_count.
  - Internal length, sum and pointer cleared.
- Frame format: LEN byte (N) -> N program bytes -> CSUM byte.
  - Valid N is 1..DEPTH.
  - CSUM must equal (sum of the N program bytes) mod 256.
- Transfer: a byte is accepted on a rising edge with in_valid & in_ready.
  - in_ready = 1 exactly when state is LEN, DATA or CSUM. It is combinational from state only.
- States:
  - IDLE: load_req -> LEN. On entry to LEN: busy=1, done=0, err=0, start=0, word_count=0, sum=0, pointer=0.
  - LEN: on accept, N=in_data.
    - N==0 or N>DEPTH -> ERR.
    - Otherwise -> DATA.
  - DATA: on accept:
    - Registered write: im_we=1 for exactly the next cycle, with im_waddr=pointer and im_wdata=in_data.
    - pointer+1; sum=(sum+in_data) mod 256; word_count+1.
    - When the byte accepted is the Nth -> CSUM.
  - CSUM: on accept:
    - in_data==sum -> RUN.
    - Otherwise -> ERR.
  - RUN: start=1 (level, held), done=1, busy=0.
  - ERR: err=1, busy=0, start=0. No further writes.
- Latency:
  - Memory write appears 1 cycle after the accepting edge.
  - start rises 1 cycle after the CSUM accepting edge. This guarantees the final write has completed before the core fetches.
  - Back-to-back accepts in DATA at one byte per cycle are supported (im_we held high across consecutive cycles).
- load_req in any state other than IDLE (LEN, DATA, CSUM, RUN, ERR) restarts the load:
  - -> LEN with the LEN entry actions above.
  - start drops the cycle after load_req.
  - A byte presented in that same cycle is not accepted as part of the new frame. in_ready is still judged by the old state; if accepted, that byte is discarded.
- Addresses N..DEPTH-1 are never written; the previous contents remain.
- pointer never wraps: N<=DEPTH bounds it. word_count reaches DEPTH (5'd16) for a full program.
- in_valid while in IDLE, RUN or ERR: ignored (in_ready=0).

Test Plan:
- Nominal: reset, load_req, stream 03,A1,B2,C3,16 -> writes (0,A1),(1,B2),(2,C3) on cycles following each accept; word_count=3; start=1, done=1 one cycle after the 16 accept.
- Bad checksum: load_req, 02,10,20,31 -> writes to 0,1 occur; err=1, start=0, done=0.
- Length bounds: LEN=00 -> err=1, no im_we. LEN=11h -> err=1, no im_we. LEN=10h with 16 bytes of 01 and CSUM=10h -> 16 writes to addresses 0..15, word_count=16, start=1.
- Backpressure and gaps: in_valid toggled 1/0 with random stalls -> identical write sequence and final state as the nominal case; in_ready low in IDLE, RUN and ERR.
- Restart and reset mid-frame:
  - load_req after 2 of 4 DATA bytes -> returns to LEN, word_count=0; next frame 01,55,55 -> write (0,55), start=1.
  - rst asserted mid-DATA -> all outputs 0 immediately, without waiting for a clock edge.
- Reload from RUN: in RUN, load_req -> start=0 the next cycle, busy=1; new frame loads and start re-asserts.
